cdb_arb: RTL

Common-data-bus arbiter between the result producers (ALU, load/store buffer) and the reorder buffer. Each cycle it selects at most one pending result, round-robin, and drives it on a single registered broadcast bus that feeds the ROB's write-back port and the RS/LSB operand snoop. Results that lose arbitration are held in a small per-producer queue. All pending results are discarded on a misprediction flush.

---
 rtl/cdb_arb_if.sv | 39 +++
 rtl/cdb_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cdb_arb_if.sv
// Common-data-bus arbiter port bundle: producer results, flush/enable, and the registered broadcast.
// Widths must match the parameters given to cdb_arb.
interface cdb_arb_if #(
   parameter int unsigned ROB_ADD_W = 4,
   parameter int unsigned REG_DAT_W = 32
);
   logic                 en;
   logic                 iMp;
   logic                 iEX_En;
   logic [ROB_ADD_W-1:0] iEX_Qd;
   logic [REG_DAT_W-1:0] iEX_Vd;
   logic [REG_DAT_W-1:0] iEX_Jt;
   logic                 iLSB_En;
   logic [ROB_ADD_W-1:0] iLSB_Qd;
   logic [REG_DAT_W-1:0] iLSB_Vd;
   logic                 oEX_Full;
   logic                 oLSB_Full;
   logic                 oCDB_En;
   logic [ROB_ADD_W-1:0] oCDB_Qd;
   logic [REG_DAT_W-1:0] oCDB_Vd;
   logic [REG_DAT_W-1:0] oCDB_Jt;
   logic                 oOvf;

   modport master (
      output en, iMp,
      output iEX_En, iEX_Qd, iEX_Vd, iEX_Jt,
      output iLSB_En, iLSB_Qd, iLSB_Vd,
      input  oEX_Full, oLSB_Full,
      input  oCDB_En, oCDB_Qd, oCDB_Vd, oCDB_Jt, oOvf
   );

   modport slave (
      input  en, iMp,
      input  iEX_En, iEX_Qd, iEX_Vd, iEX_Jt,
      input  iLSB_En, iLSB_Qd, iLSB_Vd,
      output oEX_Full, oLSB_Full,
      output oCDB_En, oCDB_Qd, oCDB_Vd, oCDB_Jt, oOvf
   );
endinterface

// File: rtl/cdb_arb.sv
// Round-robin arbiter between the ALU and load/store buffer onto a single registered CDB,
// with a QD-deep holding FIFO per producer and a misprediction flush.
module cdb_arb #(
   parameter int unsigned QD        = 2,
   parameter int unsigned ROB_ADD_W = 4,
   parameter int unsigned REG_DAT_W = 32
) (
   input logic       clk,
   input logic       rst,
   cdb_arb_if.slave  bus
);

   localparam int unsigned PW = (QD > 1) ? $clog2(QD) : 1;
   localparam int unsigned CW = $clog2(QD + 1);

   typedef enum logic {
      SRC_EX  = 1'b0,
      SRC_LSB = 1'b1
   } src_e;

   typedef struct packed {
      logic [ROB_ADD_W-1:0] qd;
      logic [REG_DAT_W-1:0] vd;
      logic [REG_DAT_W-1:0] jt;
   } ent_t;

   // Index 0 is the ALU FIFO, index 1 the LSB FIFO.
   ent_t          mem [2][QD];
   logic [PW-1:0] head [2];
   logic [PW-1:0] tail [2];
   logic [CW-1:0] cnt  [2];
   src_e          last;
   logic          cdb_en;
   ent_t          cdb;
   logic          ovf;

   ent_t          in_ent [2];
   logic          in_v   [2];
   ent_t          cand   [2];
   logic          cand_v [2];
   logic          take   [2];
   logic          pop    [2];
   logic          push   [2];
   logic          drop   [2];
   logic          full   [2];
   logic          active;
   logic          gnt_v;
   src_e          gnt;
   ent_t          gnt_ent;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      in_ent[0] = '{qd: bus.iEX_Qd,  vd: bus.iEX_Vd,  jt: bus.iEX_Jt};
      in_ent[1] = '{qd: bus.iLSB_Qd, vd: bus.iLSB_Vd, jt: '0};
      in_v[0]   = bus.iEX_En  && (bus.iEX_Qd  != '0);
      in_v[1]   = bus.iLSB_En && (bus.iLSB_Qd != '0);
      active    = bus.en && !bus.iMp;

      for (int unsigned p = 0; p < 2; p++) begin
         full[p]   = (cnt[p] == CW'(QD));
         cand_v[p] = (cnt[p] != '0) || in_v[p];
         cand[p]   = (cnt[p] != '0) ? mem[p][head[p]] : in_ent[p];
      end

      gnt_v = active && (cand_v[0] || cand_v[1]);
      if (cand_v[0] && cand_v[1])
         gnt = (last == SRC_LSB) ? SRC_EX : SRC_LSB;
      else if (cand_v[0])
         gnt = SRC_EX;
      else
         gnt = SRC_LSB;
      gnt_ent = (gnt == SRC_LSB) ? cand[1] : cand[0];

      take[0] = gnt_v && (gnt == SRC_EX);
      take[1] = gnt_v && (gnt == SRC_LSB);

      // A granted input bypasses an empty FIFO; a non-empty FIFO always enqueues to keep order.
      for (int unsigned p = 0; p < 2; p++) begin
         pop[p]  = take[p] && (cnt[p] != '0);
         push[p] = active && in_v[p] && ((cnt[p] != '0) || !take[p]) && (!full[p] || pop[p]);
         drop[p] = active && in_v[p] && full[p] && !pop[p];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned p = 0; p < 2; p++) begin
            head[p] <= '0;
            tail[p] <= '0;
            cnt[p]  <= '0;
         end
         last   <= SRC_LSB;
         cdb_en <= 1'b0;
         cdb    <= '0;
         ovf    <= 1'b0;
      end else if (!bus.en) begin
         cdb_en <= 1'b0;
      end else if (bus.iMp) begin
         for (int unsigned p = 0; p < 2; p++) begin
            head[p] <= '0;
            tail[p] <= '0;
            cnt[p]  <= '0;
         end
         cdb_en <= 1'b0;
      end else begin
         cdb_en <= gnt_v;
         if (gnt_v) begin
            cdb  <= gnt_ent;
            last <= gnt;
         end
         for (int unsigned p = 0; p < 2; p++) begin
            if (pop[p])
               head[p] <= ptr_inc(head[p]);
            if (push[p])
               tail[p] <= ptr_inc(tail[p]);
            if (push[p] && !pop[p])
               cnt[p] <= cnt[p] + 1'b1;
            else if (pop[p] && !push[p])
               cnt[p] <= cnt[p] - 1'b1;
         end
         if (drop[0] || drop[1])
            ovf <= 1'b1;
      end
   end

   // Entry storage carries no reset; validity is tracked by the counts alone.
   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < 2; p++) begin
         if (push[p])
            mem[p][tail[p]] <= in_ent[p];
      end
   end

   assign bus.oEX_Full  = full[0];
   assign bus.oLSB_Full = full[1];
   assign bus.oCDB_En   = cdb_en;
   assign bus.oCDB_Qd   = cdb.qd;
   assign bus.oCDB_Vd   = cdb.vd;
   assign bus.oCDB_Jt   = cdb.jt;
   assign bus.oOvf      = ovf;

endmodule
